axi_master_arbiter: RTL and testbench

- Shares the core's single AXI4 master port (io_master_*) between two requesters: IFU (instruction fetch, read-only) and LSU (load/store, read or write).
- Accepts one outstanding transaction at a time, arbitrates round-robin, and drives single-beat AXI bursts.
- Returns each response to the requester that issued the transaction.
- Sits between the IFU/LSU and the SoC crossbar, and replaces the ad-hoc fetch/execute sequencing in the AXI path.

---
 rtl/axi_pkg.sv | 36 +++
 rtl/axi_master_arbiter_rr_arb2.sv | 48 ++++
 rtl/axi_master_arbiter.sv | 243 ++++++++++++++++++++++++
 tb/tb_axi_master_arbiter.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_pkg.sv
// Shared AXI4 encodings and arbiter types for the core's master-port arbiter.
package axi_pkg;

    localparam logic [1:0] AXI_BURST_INCR  = 2'b01;

    localparam logic [2:0] AXI_SIZE_1      = 3'd0;
    localparam logic [2:0] AXI_SIZE_2      = 3'd1;
    localparam logic [2:0] AXI_SIZE_4      = 3'd2;

    localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
    localparam logic [1:0] AXI_RESP_EXOKAY = 2'b01;
    localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
    localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_IFU_AR  = 3'd1,
        ST_IFU_R   = 3'd2,
        ST_LSU_AR  = 3'd3,
        ST_LSU_R   = 3'd4,
        ST_LSU_AWW = 3'd5,
        ST_LSU_B   = 3'd6
    } arb_state_e;

    typedef enum logic {
        REQ_IFU = 1'b0,
        REQ_LSU = 1'b1
    } req_e;

    // Anything other than OKAY is reported to the requester as an error;
    // this core never issues exclusive accesses, so EXOKAY is unexpected.
    function automatic logic resp_is_err(input logic [1:0] resp);
        return resp != AXI_RESP_OKAY;
    endfunction

endpackage

// File: rtl/axi_master_arbiter_rr_arb2.sv
// Two-way arbiter: round-robin on ties (or fixed priority to requester 1),
// remembering the last winner. Bit 0 is the IFU, bit 1 the LSU.
module rr_arb2
    import axi_pkg::*;
#(
    parameter bit RR_EN = 1'b1
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       en_i,
    input  logic [1:0] req_i,
    output logic [1:0] gnt_o
);

    req_e last_q;
    req_e last_d;
    req_e winner;
    logic any_req;

    // Pick the winner from the current requests and the previous grant.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path leaves it unassigned and no latch is inferred.
        winner  = REQ_LSU;
        last_d  = last_q;
        any_req = en_i && (req_i != 2'b00);
        if (req_i[0] && req_i[1]) begin
            winner = (RR_EN && (last_q == REQ_LSU)) ? REQ_IFU : REQ_LSU;
        end else if (req_i[0]) begin
            winner = REQ_IFU;
        end
        if (any_req) begin
            last_d = winner;
        end
        gnt_o[0] = any_req && (winner == REQ_IFU);
        gnt_o[1] = any_req && (winner == REQ_LSU);
    end

    // Remember who won last; reset favours the LSU on the first tie.
    always_ff @(posedge clock or negedge reset) begin
        // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
        if (!reset) begin
            last_q <= REQ_IFU;
        end else begin
            last_q <= last_d;
        end
    end

endmodule

// File: rtl/axi_master_arbiter.sv
// Shares one AXI4 master port between the IFU (reads) and the LSU (reads and
// writes). One single-beat transaction in flight; responses go back to the
// requester that issued it.
module axi_master_arbiter
    import axi_pkg::*;
#(
    parameter logic [3:0] IFU_ID = 4'd0,
    parameter logic [3:0] LSU_ID = 4'd1,
    parameter bit         RR_EN  = 1'b1
) (
    input  logic        clock,
    input  logic        reset,

    input  logic        ifu_req_valid,
    output logic        ifu_req_ready,
    input  logic [31:0] ifu_addr,
    output logic        ifu_resp_valid,
    output logic [31:0] ifu_resp_data,
    output logic        ifu_resp_err,

    input  logic        lsu_req_valid,
    output logic        lsu_req_ready,
    input  logic        lsu_req_wen,
    input  logic [31:0] lsu_addr,
    input  logic [2:0]  lsu_size,
    input  logic [31:0] lsu_wdata,
    input  logic [3:0]  lsu_wstrb,
    output logic        lsu_resp_valid,
    output logic [31:0] lsu_resp_rdata,
    output logic        lsu_resp_err,

    input  logic        io_master_awready,
    output logic        io_master_awvalid,
    output logic [31:0] io_master_awaddr,
    output logic [3:0]  io_master_awid,
    output logic [7:0]  io_master_awlen,
    output logic [2:0]  io_master_awsize,
    output logic [1:0]  io_master_awburst,

    input  logic        io_master_wready,
    output logic        io_master_wvalid,
    output logic [31:0] io_master_wdata,
    output logic [3:0]  io_master_wstrb,
    output logic        io_master_wlast,

    output logic        io_master_bready,
    input  logic        io_master_bvalid,
    input  logic [1:0]  io_master_bresp,
    input  logic [3:0]  io_master_bid,

    input  logic        io_master_arready,
    output logic        io_master_arvalid,
    output logic [31:0] io_master_araddr,
    output logic [3:0]  io_master_arid,
    output logic [7:0]  io_master_arlen,
    output logic [2:0]  io_master_arsize,
    output logic [1:0]  io_master_arburst,

    output logic        io_master_rready,
    input  logic        io_master_rvalid,
    input  logic [1:0]  io_master_rresp,
    input  logic [31:0] io_master_rdata,
    input  logic        io_master_rlast,
    input  logic [3:0]  io_master_rid
);

    arb_state_e  state_q;
    logic [31:0] addr_q;
    logic [2:0]  size_q;
    logic [3:0]  id_q;
    logic [31:0] wdata_q;
    logic [3:0]  wstrb_q;
    logic        arvalid_q, rready_q, awvalid_q, wvalid_q, bready_q;
    logic        aw_done_q, w_done_q;
    logic        ifu_resp_valid_q, ifu_resp_err_q;
    logic [31:0] ifu_resp_data_q;
    logic        lsu_resp_valid_q, lsu_resp_err_q;
    logic [31:0] lsu_resp_rdata_q;

    logic        arb_en;
    logic [1:0]  gnt;
    logic        aw_hs, w_hs;

    // Arbitrate only while idle and out of reset, so nothing is acknowledged during reset.
    assign arb_en = (state_q == ST_IDLE) && reset;

    rr_arb2 #(
        .RR_EN (RR_EN)
    ) u_rr_arb2 (
        .clock (clock),
        .reset (reset),
        .en_i  (arb_en),
        .req_i ({lsu_req_valid, ifu_req_valid}),
        .gnt_o (gnt)
    );

    // The accept pulse is the grant itself: the request fields are latched on this edge.
    assign ifu_req_ready = gnt[0];
    assign lsu_req_ready = gnt[1];

    assign aw_hs = awvalid_q && io_master_awready;
    assign w_hs  = wvalid_q && io_master_wready;

    // Transaction sequencer with all AXI valids/readies and responses registered.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q          <= ST_IDLE;
            addr_q           <= '0;
            size_q           <= '0;
            id_q             <= '0;
            wdata_q          <= '0;
            wstrb_q          <= '0;
            arvalid_q        <= 1'b0;
            rready_q         <= 1'b0;
            awvalid_q        <= 1'b0;
            wvalid_q         <= 1'b0;
            bready_q         <= 1'b0;
            aw_done_q        <= 1'b0;
            w_done_q         <= 1'b0;
            ifu_resp_valid_q <= 1'b0;
            ifu_resp_err_q   <= 1'b0;
            ifu_resp_data_q  <= '0;
            lsu_resp_valid_q <= 1'b0;
            lsu_resp_err_q   <= 1'b0;
            lsu_resp_rdata_q <= '0;
        end else begin
            ifu_resp_valid_q <= 1'b0;
            lsu_resp_valid_q <= 1'b0;
            unique case (state_q)
                ST_IDLE: begin
                    if (gnt[0]) begin
                        addr_q    <= ifu_addr;
                        size_q    <= AXI_SIZE_4;
                        id_q      <= IFU_ID;
                        wdata_q   <= '0;
                        wstrb_q   <= '0;
                        arvalid_q <= 1'b1;
                        state_q   <= ST_IFU_AR;
                    end else if (gnt[1]) begin
                        addr_q  <= lsu_addr;
                        size_q  <= lsu_size;
                        id_q    <= LSU_ID;
                        wdata_q <= lsu_wdata;
                        wstrb_q <= lsu_wstrb;
                        if (lsu_req_wen) begin
                            awvalid_q <= 1'b1;
                            wvalid_q  <= 1'b1;
                            aw_done_q <= 1'b0;
                            w_done_q  <= 1'b0;
                            state_q   <= ST_LSU_AWW;
                        end else begin
                            arvalid_q <= 1'b1;
                            state_q   <= ST_LSU_AR;
                        end
                    end
                end
                ST_IFU_AR, ST_LSU_AR: begin
                    if (io_master_arready) begin
                        arvalid_q <= 1'b0;
                        rready_q  <= 1'b1;
                        state_q   <= (state_q == ST_IFU_AR) ? ST_IFU_R : ST_LSU_R;
                    end
                end
                ST_IFU_R: begin
                    if (io_master_rvalid) begin
                        rready_q         <= 1'b0;
                        state_q          <= ST_IDLE;
                        ifu_resp_valid_q <= 1'b1;
                        ifu_resp_data_q  <= io_master_rdata;
                        ifu_resp_err_q   <= resp_is_err(io_master_rresp) ||
                                            (io_master_rid != IFU_ID) || !io_master_rlast;
                    end
                end
                ST_LSU_R: begin
                    if (io_master_rvalid) begin
                        rready_q         <= 1'b0;
                        state_q          <= ST_IDLE;
                        lsu_resp_valid_q <= 1'b1;
                        lsu_resp_rdata_q <= io_master_rdata;
                        lsu_resp_err_q   <= resp_is_err(io_master_rresp) ||
                                            (io_master_rid != LSU_ID) || !io_master_rlast;
                    end
                end
                ST_LSU_AWW: begin
                    if (aw_hs) begin
                        awvalid_q <= 1'b0;
                        aw_done_q <= 1'b1;
                    end
                    if (w_hs) begin
                        wvalid_q <= 1'b0;
                        w_done_q <= 1'b1;
                    end
                    if ((aw_done_q || aw_hs) && (w_done_q || w_hs)) begin
                        bready_q <= 1'b1;
                        state_q  <= ST_LSU_B;
                    end
                end
                ST_LSU_B: begin
                    if (io_master_bvalid) begin
                        bready_q         <= 1'b0;
                        state_q          <= ST_IDLE;
                        lsu_resp_valid_q <= 1'b1;
                        lsu_resp_rdata_q <= '0;
                        lsu_resp_err_q   <= resp_is_err(io_master_bresp) ||
                                            (io_master_bid != LSU_ID);
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign io_master_arvalid = arvalid_q;
    assign io_master_araddr  = addr_q;
    assign io_master_arid    = id_q;
    assign io_master_arsize  = size_q;
    assign io_master_arlen   = 8'd0;
    assign io_master_arburst = AXI_BURST_INCR;
    assign io_master_rready  = rready_q;

    assign io_master_awvalid = awvalid_q;
    assign io_master_awaddr  = addr_q;
    assign io_master_awid    = id_q;
    assign io_master_awsize  = size_q;
    assign io_master_awlen   = 8'd0;
    assign io_master_awburst = AXI_BURST_INCR;

    assign io_master_wvalid  = wvalid_q;
    assign io_master_wdata   = wdata_q;
    assign io_master_wstrb   = wstrb_q;
    assign io_master_wlast   = wvalid_q;
    assign io_master_bready  = bready_q;

    assign ifu_resp_valid = ifu_resp_valid_q;
    assign ifu_resp_data  = ifu_resp_data_q;
    assign ifu_resp_err   = ifu_resp_err_q;
    assign lsu_resp_valid = lsu_resp_valid_q;
    assign lsu_resp_rdata = lsu_resp_rdata_q;
    assign lsu_resp_err   = lsu_resp_err_q;

endmodule

// File: tb/tb_axi_master_arbiter.sv
// Directed bench for axi_master_arbiter: inputs driven 1 time unit after the
// rising edge, outputs sampled on the falling edge.
module tb_axi_master_arbiter;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        ifu_req_valid = 1'b0, ifu_req_ready;
    logic [31:0] ifu_addr = '0;
    logic        ifu_resp_valid, ifu_resp_err;
    logic [31:0] ifu_resp_data;
    logic        lsu_req_valid = 1'b0, lsu_req_ready, lsu_req_wen = 1'b0;
    logic [31:0] lsu_addr = '0, lsu_wdata = '0;
    logic [2:0]  lsu_size = '0;
    logic [3:0]  lsu_wstrb = '0;
    logic        lsu_resp_valid, lsu_resp_err;
    logic [31:0] lsu_resp_rdata;
    logic        awready = 1'b0, awvalid, wready = 1'b0, wvalid, wlast;
    logic [31:0] awaddr, wdata, araddr;
    logic [3:0]  awid, wstrb, arid;
    logic [7:0]  awlen, arlen;
    logic [2:0]  awsize, arsize;
    logic [1:0]  awburst, arburst;
    logic        bready, bvalid = 1'b0;
    logic [1:0]  bresp = '0;
    logic [3:0]  bid = '0;
    logic        arready = 1'b0, arvalid, rready, rvalid = 1'b0, rlast = 1'b0;
    logic [1:0]  rresp = '0;
    logic [31:0] rdata = '0;
    logic [3:0]  rid = '0;

    int vectors = 0;
    int miscompares = 0;

    axi_master_arbiter #(.IFU_ID(4'd0), .LSU_ID(4'd1), .RR_EN(1'b1)) dut (
        .clock(clock), .reset(reset),
        .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready), .ifu_addr(ifu_addr),
        .ifu_resp_valid(ifu_resp_valid), .ifu_resp_data(ifu_resp_data), .ifu_resp_err(ifu_resp_err),
        .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready), .lsu_req_wen(lsu_req_wen),
        .lsu_addr(lsu_addr), .lsu_size(lsu_size), .lsu_wdata(lsu_wdata), .lsu_wstrb(lsu_wstrb),
        .lsu_resp_valid(lsu_resp_valid), .lsu_resp_rdata(lsu_resp_rdata), .lsu_resp_err(lsu_resp_err),
        .io_master_awready(awready), .io_master_awvalid(awvalid), .io_master_awaddr(awaddr),
        .io_master_awid(awid), .io_master_awlen(awlen), .io_master_awsize(awsize), .io_master_awburst(awburst),
        .io_master_wready(wready), .io_master_wvalid(wvalid), .io_master_wdata(wdata),
        .io_master_wstrb(wstrb), .io_master_wlast(wlast),
        .io_master_bready(bready), .io_master_bvalid(bvalid), .io_master_bresp(bresp), .io_master_bid(bid),
        .io_master_arready(arready), .io_master_arvalid(arvalid), .io_master_araddr(araddr),
        .io_master_arid(arid), .io_master_arlen(arlen), .io_master_arsize(arsize), .io_master_arburst(arburst),
        .io_master_rready(rready), .io_master_rvalid(rvalid), .io_master_rresp(rresp),
        .io_master_rdata(rdata), .io_master_rlast(rlast), .io_master_rid(rid)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic sample();
        @(negedge clock);
    endtask

    // Zero-wait slave for one read, starting in the cycle after the grant.
    // Returns just after the edge that opens the response cycle.
    task automatic serve_read(input logic [3:0] id, input logic [31:0] data,
                              input logic [1:0] resp, input logic last, input bit owner_lsu);
        tick();
        if (owner_lsu) lsu_req_valid = 1'b0; else ifu_req_valid = 1'b0;
        arready = 1'b1;
        sample();
        vectors++; if ({arvalid, rready, ifu_req_ready, lsu_req_ready} !== 4'b1000) begin miscompares++; $display("FAIL rd_ar_phase: got %b expected 1000", {arvalid, rready, ifu_req_ready, lsu_req_ready}); end
        tick();
        arready = 1'b0; rvalid = 1'b1; rid = id; rdata = data; rresp = resp; rlast = last;
        sample();
        vectors++; if ({arvalid, rready} !== 2'b01) begin miscompares++; $display("FAIL rd_r_phase: got %b expected 01", {arvalid, rready}); end
        tick();
        rvalid = 1'b0; rlast = 1'b0;
    endtask

    task automatic test_reset();
        ifu_req_valid = 1'b1; lsu_req_valid = 1'b1;
        sample();
        vectors++; if ({ifu_req_ready, lsu_req_ready, ifu_resp_valid, lsu_resp_valid, arvalid, awvalid, wvalid, rready, bready} !== 9'b0) begin miscompares++; $display("FAIL reset_outputs: got %b expected 0", {ifu_req_ready, lsu_req_ready, ifu_resp_valid, lsu_resp_valid, arvalid, awvalid, wvalid, rready, bready}); end
        vectors++; if ({araddr, awaddr, wdata, arlen, awlen, arburst, awburst} !== {64'h0, 32'h0, 16'h0, 2'b01, 2'b01}) begin miscompares++; $display("FAIL reset_regs: got %h expected const", {araddr, awaddr, wdata, arlen, awlen, arburst, awburst}); end
        ifu_req_valid = 1'b0; lsu_req_valid = 1'b0;
        tick();
        reset = 1'b1;
        sample();
        vectors++; if ({ifu_req_ready, lsu_req_ready, arvalid, awvalid} !== 4'b0) begin miscompares++; $display("FAIL reset_release_idle: got %b expected 0000", {ifu_req_ready, lsu_req_ready, arvalid, awvalid}); end
    endtask

    task automatic test_fetch();
        tick();
        ifu_req_valid = 1'b1; ifu_addr = 32'h8000_0000;
        sample();
        vectors++; if ({ifu_req_ready, lsu_req_ready, arvalid} !== 3'b100) begin miscompares++; $display("FAIL fetch_grant: got %b expected 100", {ifu_req_ready, lsu_req_ready, arvalid}); end
        tick();
        ifu_req_valid = 1'b0; arready = 1'b1;
        sample();
        vectors++; if ({arvalid, araddr, arid, arsize, arlen, arburst} !== {1'b1, 32'h8000_0000, 4'd0, 3'd2, 8'd0, 2'b01}) begin miscompares++; $display("FAIL fetch_ar: got %h expected %h", {arvalid, araddr, arid, arsize, arlen, arburst}, {1'b1, 32'h8000_0000, 4'd0, 3'd2, 8'd0, 2'b01}); end
        tick();
        arready = 1'b0; rvalid = 1'b1; rdata = 32'h0000_0413; rresp = 2'b00; rid = 4'd0; rlast = 1'b1;
        sample();
        vectors++; if ({rready, arvalid, ifu_resp_valid} !== 3'b100) begin miscompares++; $display("FAIL fetch_r: got %b expected 100", {rready, arvalid, ifu_resp_valid}); end
        tick();
        rvalid = 1'b0; rlast = 1'b0;
        sample();
        vectors++; if ({ifu_resp_valid, ifu_resp_data, ifu_resp_err, lsu_resp_valid} !== {1'b1, 32'h0000_0413, 1'b0, 1'b0}) begin miscompares++; $display("FAIL fetch_resp: got %h expected %h", {ifu_resp_valid, ifu_resp_data, ifu_resp_err, lsu_resp_valid}, {1'b1, 32'h0000_0413, 1'b0, 1'b0}); end
        tick();
        sample();
        vectors++; if ({ifu_resp_valid, rready} !== 2'b00) begin miscompares++; $display("FAIL fetch_pulse_end: got %b expected 00", {ifu_resp_valid, rready}); end
    endtask

    task automatic test_round_robin();
        reset = 1'b0;
        tick();
        reset = 1'b1;
        tick();
        ifu_req_valid = 1'b1; ifu_addr = 32'h8000_0100;
        lsu_req_valid = 1'b1; lsu_req_wen = 1'b0; lsu_addr = 32'h2000_0000; lsu_size = 3'd2;
        sample();
        vectors++; if ({ifu_req_ready, lsu_req_ready} !== 2'b01) begin miscompares++; $display("FAIL rr_first_lsu: got %b expected 01", {ifu_req_ready, lsu_req_ready}); end
        serve_read(4'd1, 32'h1111_1111, 2'b00, 1'b1, 1'b1);
        lsu_req_valid = 1'b1; lsu_addr = 32'h2000_0004;
        sample();
        vectors++; if ({lsu_resp_valid, lsu_resp_rdata, ifu_req_ready, lsu_req_ready} !== {1'b1, 32'h1111_1111, 2'b10}) begin miscompares++; $display("FAIL rr_second_ifu: got %h expected %h", {lsu_resp_valid, lsu_resp_rdata, ifu_req_ready, lsu_req_ready}, {1'b1, 32'h1111_1111, 2'b10}); end
        serve_read(4'd0, 32'h2222_2222, 2'b00, 1'b1, 1'b0);
        ifu_req_valid = 1'b1;
        sample();
        vectors++; if ({ifu_resp_valid, ifu_resp_data, ifu_req_ready, lsu_req_ready} !== {1'b1, 32'h2222_2222, 2'b01}) begin miscompares++; $display("FAIL rr_third_lsu: got %h expected %h", {ifu_resp_valid, ifu_resp_data, ifu_req_ready, lsu_req_ready}, {1'b1, 32'h2222_2222, 2'b01}); end
        serve_read(4'd1, 32'h3333_3333, 2'b00, 1'b1, 1'b1);
        ifu_req_valid = 1'b0;
        sample();
        vectors++; if ({lsu_resp_valid, lsu_resp_rdata, ifu_resp_valid, ifu_req_ready} !== {1'b1, 32'h3333_3333, 2'b00}) begin miscompares++; $display("FAIL rr_third_resp: got %h expected %h", {lsu_resp_valid, lsu_resp_rdata, ifu_resp_valid, ifu_req_ready}, {1'b1, 32'h3333_3333, 2'b00}); end
    endtask

    task automatic test_store();
        tick();
        lsu_req_valid = 1'b1; lsu_req_wen = 1'b1; lsu_addr = 32'h0F00_0001; lsu_size = 3'd0;
        lsu_wdata = 32'h0000_AB00; lsu_wstrb = 4'b0010;
        sample();
        vectors++; if (lsu_req_ready !== 1'b1) begin miscompares++; $display("FAIL store_grant: got %b expected 1", lsu_req_ready); end
        tick();
        lsu_req_valid = 1'b0; ifu_req_valid = 1'b1; ifu_addr = 32'h8000_0008; wready = 1'b1;
        sample();
        vectors++; if ({awvalid, wvalid, wlast, awaddr, awsize, awid, wdata, wstrb} !== {3'b111, 32'h0F00_0001, 3'd0, 4'd1, 32'h0000_AB00, 4'b0010}) begin miscompares++; $display("FAIL store_aww: got %h expected %h", {awvalid, wvalid, wlast, awaddr, awsize, awid, wdata, wstrb}, {3'b111, 32'h0F00_0001, 3'd0, 4'd1, 32'h0000_AB00, 4'b0010}); end
        vectors++; if ({arvalid, ifu_req_ready} !== 2'b00) begin miscompares++; $display("FAIL store_no_fetch: got %b expected 00", {arvalid, ifu_req_ready}); end
        tick();
        wready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            sample();
            vectors++; if ({awvalid, wvalid, wlast, arvalid} !== 4'b1000) begin miscompares++; $display("FAIL store_aw_hold: got %b expected 1000", {awvalid, wvalid, wlast, arvalid}); end
            tick();
        end
        awready = 1'b1;
        sample();
        vectors++; if ({awvalid, wvalid, bready} !== 3'b100) begin miscompares++; $display("FAIL store_aw_hs: got %b expected 100", {awvalid, wvalid, bready}); end
        tick();
        awready = 1'b0; bvalid = 1'b1; bresp = 2'b00; bid = 4'd1;
        sample();
        vectors++; if ({awvalid, bready, arvalid, lsu_resp_valid} !== 4'b0100) begin miscompares++; $display("FAIL store_b: got %b expected 0100", {awvalid, bready, arvalid, lsu_resp_valid}); end
        tick();
        bvalid = 1'b0;
        sample();
        vectors++; if ({lsu_resp_valid, lsu_resp_rdata, lsu_resp_err, bready, ifu_req_ready} !== {1'b1, 32'h0, 1'b0, 2'b01}) begin miscompares++; $display("FAIL store_resp: got %h expected %h", {lsu_resp_valid, lsu_resp_rdata, lsu_resp_err, bready, ifu_req_ready}, {1'b1, 32'h0, 1'b0, 2'b01}); end
        serve_read(4'd0, 32'h0000_0013, 2'b00, 1'b1, 1'b0);
        sample();
        vectors++; if ({ifu_resp_valid, ifu_resp_data, ifu_resp_err} !== {1'b1, 32'h0000_0013, 1'b0}) begin miscompares++; $display("FAIL store_after_fetch: got %h expected %h", {ifu_resp_valid, ifu_resp_data, ifu_resp_err}, {1'b1, 32'h0000_0013, 1'b0}); end
    endtask

    task automatic test_load_err();
        logic [3:0]  ids[4]   = '{4'd1, 4'd0, 4'd1, 4'd1};
        logic [1:0]  resps[4] = '{2'b10, 2'b00, 2'b00, 2'b00};
        logic        lasts[4] = '{1'b1, 1'b1, 1'b0, 1'b1};
        logic [31:0] datas[4] = '{32'hDEAD_BEEF, 32'h1234_5678, 32'hCAFE_F00D, 32'h0BAD_F00D};
        logic        errs[4]  = '{1'b1, 1'b1, 1'b1, 1'b0};
        for (int i = 0; i < 4; i++) begin
            tick();
            lsu_req_valid = 1'b1; lsu_req_wen = 1'b0; lsu_addr = 32'h1000_0004; lsu_size = 3'd2;
            sample();
            vectors++; if (lsu_req_ready !== 1'b1) begin miscompares++; $display("FAIL load_grant[%0d]: got %b expected 1", i, lsu_req_ready); end
            serve_read(ids[i], datas[i], resps[i], lasts[i], 1'b1);
            sample();
            vectors++; if ({lsu_resp_valid, lsu_resp_rdata, lsu_resp_err, ifu_resp_valid} !== {1'b1, datas[i], errs[i], 1'b0}) begin miscompares++; $display("FAIL load_resp[%0d]: got %h expected %h", i, {lsu_resp_valid, lsu_resp_rdata, lsu_resp_err, ifu_resp_valid}, {1'b1, datas[i], errs[i], 1'b0}); end
        end
    endtask

    task automatic test_reset_mid();
        tick();
        lsu_req_valid = 1'b1; lsu_req_wen = 1'b0; lsu_addr = 32'h3000_0000; lsu_size = 3'd2;
        sample();
        vectors++; if (lsu_req_ready !== 1'b1) begin miscompares++; $display("FAIL rmid_grant: got %b expected 1", lsu_req_ready); end
        tick();
        lsu_req_valid = 1'b0; arready = 1'b1;
        tick();
        arready = 1'b0; rvalid = 1'b1; rid = 4'd1; rdata = 32'hAAAA_5555; rresp = 2'b00; rlast = 1'b1;
        #1;
        vectors++; if (rready !== 1'b1) begin miscompares++; $display("FAIL rmid_in_r: got %b expected 1", rready); end
        reset = 1'b0;
        #1;
        vectors++; if ({arvalid, awvalid, wvalid, rready, bready, ifu_resp_valid, lsu_resp_valid} !== 7'b0) begin miscompares++; $display("FAIL rmid_abort: got %b expected 0", {arvalid, awvalid, wvalid, rready, bready, ifu_resp_valid, lsu_resp_valid}); end
        tick();
        sample();
        vectors++; if ({lsu_resp_valid, rready} !== 2'b00) begin miscompares++; $display("FAIL rmid_held: got %b expected 00", {lsu_resp_valid, rready}); end
        tick();
        reset = 1'b1; rvalid = 1'b0; rlast = 1'b0;
        sample();
        vectors++; if ({lsu_resp_valid, rready} !== 2'b00) begin miscompares++; $display("FAIL rmid_release: got %b expected 00", {lsu_resp_valid, rready}); end
        tick();
        ifu_req_valid = 1'b1; ifu_addr = 32'h8000_0004;
        sample();
        vectors++; if ({ifu_req_ready, lsu_resp_valid} !== 2'b10) begin miscompares++; $display("FAIL rmid_fetch_grant: got %b expected 10", {ifu_req_ready, lsu_resp_valid}); end
        serve_read(4'd0, 32'h0010_0073, 2'b00, 1'b1, 1'b0);
        sample();
        vectors++; if ({ifu_resp_valid, ifu_resp_data, ifu_resp_err, lsu_resp_valid} !== {1'b1, 32'h0010_0073, 2'b00}) begin miscompares++; $display("FAIL rmid_fetch_resp: got %h expected %h", {ifu_resp_valid, ifu_resp_data, ifu_resp_err, lsu_resp_valid}, {1'b1, 32'h0010_0073, 2'b00}); end
    endtask

    task automatic test_back_to_back_aww();
        logic [1:0] bresps[3] = '{2'b00, 2'b11, 2'b00};
        logic [3:0] bids[3]   = '{4'd1, 4'd1, 4'd0};
        logic       errs[3]   = '{1'b0, 1'b1, 1'b1};
        for (int i = 0; i < 3; i++) begin
            tick();
            lsu_req_valid = 1'b1; lsu_req_wen = 1'b1; lsu_addr = 32'h0F00_0010; lsu_size = 3'd2;
            lsu_wdata = 32'h5A5A_5A5A; lsu_wstrb = 4'hF;
            sample();
            vectors++; if (lsu_req_ready !== 1'b1) begin miscompares++; $display("FAIL aww_grant[%0d]: got %b expected 1", i, lsu_req_ready); end
            tick();
            lsu_req_valid = 1'b0; awready = 1'b1; wready = 1'b1;
            sample();
            vectors++; if ({awvalid, wvalid, bready} !== 3'b110) begin miscompares++; $display("FAIL aww_both[%0d]: got %b expected 110", i, {awvalid, wvalid, bready}); end
            tick();
            awready = 1'b0; wready = 1'b0; bvalid = 1'b1; bresp = bresps[i]; bid = bids[i];
            sample();
            vectors++; if ({awvalid, wvalid, bready} !== 3'b001) begin miscompares++; $display("FAIL aww_b_next[%0d]: got %b expected 001", i, {awvalid, wvalid, bready}); end
            tick();
            bvalid = 1'b0;
            sample();
            vectors++; if ({lsu_resp_valid, lsu_resp_err, bready} !== {1'b1, errs[i], 1'b0}) begin miscompares++; $display("FAIL aww_resp[%0d]: got %b expected %b", i, {lsu_resp_valid, lsu_resp_err, bready}, {1'b1, errs[i], 1'b0}); end
        end
    endtask

    initial begin
        test_reset();
        test_fetch();
        test_round_robin();
        test_store();
        test_load_err();
        test_reset_mid();
        test_back_to_back_aww();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "bench did not complete");
    end

endmodule
